// File: rtl/mac_result_divider_pkg.sv
// mac_result_divider_pkg
//   Shared definitions for the MAC result divider: FSM state encoding, the
//   default operand width and helpers that derive the dividend and
//   iteration-counter widths from an operand width.
package mac_result_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DEF_WIDTH = 8;

  // Dividend (and quotient) width: accumulator of two WIDTH products plus carry.
  function automatic int unsigned dividend_width(input int unsigned w);
    return 2 * w + 1;
  endfunction

  // Counter width able to hold dividend_width-1 iterations.
  function automatic int unsigned counter_width(input int unsigned w);
    return $clog2(2 * w + 1);
  endfunction

  localparam int unsigned DEF_DIVIDEND_W = dividend_width(DEF_WIDTH);
  localparam int unsigned DEF_COUNT_W    = counter_width(DEF_WIDTH);

endpackage

// File: rtl/mac_result_divider_div_restore_step.sv
// div_restore_step
//   One combinational iteration of restoring division.
//   Ports:
//     rem_in   [WIDTH:0]   partial remainder before this step
//     bit_in               next dividend bit (MSB first)
//     divisor  [WIDTH-1:0] divisor
//     rem_out  [WIDTH:0]   partial remainder after this step
//     q_bit                quotient bit produced by this step
module div_restore_step
  import mac_result_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;

  // Shift in the next bit, trial-subtract, keep the difference if it fits.
  // The difference is only used when the shifted value is >= divisor, so the
  // truncated WIDTH+1-bit subtraction is exact in that case.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    ge_s      = (shifted_s >= {2'b00, divisor});
    diff_s    = shifted_s[WIDTH:0] - {1'b0, divisor};
    if (ge_s) begin
      rem_out = diff_s;
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted_s[WIDTH:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/mac_result_divider.sv
// mac_result_divider
//   Iterative restoring divider for accumulated MAC sums. One quotient bit
//   per cycle, one division in flight, valid/ready on both sides.
//   Ports:
//     clk, rst_n                         clock, synchronous active-low reset
//     in_valid / in_ready                operand handshake
//     dividend [2*WIDTH:0]               unsigned accumulator value
//     divisor  [WIDTH-1:0]               unsigned divisor
//     out_valid / out_ready              result handshake
//     quotient [2*WIDTH:0], remainder [WIDTH-1:0], div_by_zero   result
module mac_result_divider
  import mac_result_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*WIDTH:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*WIDTH:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned DIV_W = dividend_width(WIDTH);
  localparam int unsigned CNT_W = counter_width(WIDTH);

  div_state_e       state_r;
  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after DIV_W steps this register holds the quotient.
  logic [DIV_W-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dbz_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [WIDTH:0]   rem_next_s;
  logic             q_bit_s;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[DIV_W-1]),
    .divisor (dvs_r),
    .rem_out (rem_next_s),
    .q_bit   (q_bit_s)
  );

  // Divider FSM: operand capture, iteration and result hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      dvd_r       <= '0;
      dvs_r       <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      dbz_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            dvs_r       <= divisor;
            rem_r       <= '0;
            cnt_r       <= CNT_W'(DIV_W - 1);
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            if (divisor == '0) begin
              dvd_r   <= '1;
              dbz_r   <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              dvd_r   <= dividend;
              dbz_r   <= 1'b0;
              state_r <= ST_CALC;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_CALC: begin
          rem_r <= rem_next_s;
          dvd_r <= {dvd_r[DIV_W-2:0], q_bit_s};
          if (cnt_r == '0) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_DONE: begin
          // out_valid rises one cycle after entering DONE; results are frozen here.
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = dvd_r;
  assign remainder   = rem_r[WIDTH-1:0];
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mac_result_divider.sv
// Scoreboard testbench for mac_result_divider (WIDTH=8).
module tb_mac_result_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [16:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  mac_result_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: compare each accepted result against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got out_valid with quotient %0d, expected no result", quotient);
      end else begin
        e = sb_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  task automatic push_exp(input logic [16:0] q, input logic [7:0] r, input logic dbz);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [16:0] dvd, input logic [7:0] dvs);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
  endtask

  // Wait until in_ready, let the accepting edge pass, then scramble operands.
  task automatic wait_accept();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready low for %0d cycles, expected high", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 17'h0AAAA;
    divisor  = 8'h5A;
  endtask

  // Called just after the accepting edge; counts edges until out_valid.
  task automatic wait_valid(input string name, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check(name, lat, exp_lat);
  endtask

  task automatic wait_clear();
    int n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic run(input string name, input logic [16:0] dvd, input logic [7:0] dvs,
                     input logic [16:0] q, input logic [7:0] r, input logic dbz, input int lat);
    push_exp(q, r, dbz);
    drive(dvd, dvs);
    wait_accept();
    wait_valid(name, lat);
    wait_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = 17'd0;
    divisor   = 8'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);

    run("lat_1000_7",    17'd1000,   8'd7,   17'd142,     8'd6, 1'b0, 18);
    run("lat_max_255",   17'd131071, 8'd255, 17'd514,     8'd1, 1'b0, 18);
    run("lat_5_9",       17'd5,      8'd9,   17'd0,       8'd5, 1'b0, 18);
    run("lat_div0",      17'd1234,   8'd0,   17'h1FFFF,   8'd0, 1'b1, 1);
    run("lat_max_1",     17'd131071, 8'd1,   17'd131071,  8'd0, 1'b0, 18);
    run("lat_0_3",       17'd0,      8'd3,   17'd0,       8'd0, 1'b0, 18);

    // Backpressure: result held while a new pair waits.
    out_ready = 1'b0;
    push_exp(17'd142, 8'd6, 1'b0);
    drive(17'd1000, 8'd7);
    wait_accept();
    wait_valid("lat_bp", 18);
    push_exp(17'd0, 8'd5, 1'b0);
    drive(17'd5, 8'd9);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_quotient", quotient, 142);
      check("bp_remainder", remainder, 6);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_accept();
    wait_valid("lat_after_bp", 18);
    wait_clear();

    // Reset during CALC discards the division.
    drive(17'd1000, 8'd7);
    wait_accept();
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    check("mid_rst_in_ready", in_ready, 1);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mid_rst_no_valid", seen, 0);
    run("lat_100_10", 17'd100, 8'd10, 17'd10, 8'd0, 1'b0, 18);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
